// File: rtl/seq_stage_read_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_stage_read_pkg: shared sizes and opcode constants for the read stage |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package seq_stage_read_pkg;

    localparam int DEFAULT_REG_ADDR_SIZE = 3;
    localparam int DEFAULT_REG_COUNT     = 1 << DEFAULT_REG_ADDR_SIZE;
    localparam int DEFAULT_DATA_SIZE     = 32;
    localparam int DEFAULT_OPCODE_SIZE   = 7;

    localparam logic [DEFAULT_OPCODE_SIZE-1:0] OP_LOAD    = 7'b0000011;
    localparam logic [DEFAULT_OPCODE_SIZE-1:0] OP_STORE   = 7'b0100011;
    localparam logic [DEFAULT_OPCODE_SIZE-1:0] OP_ALU     = 7'b0110011;
    localparam logic [DEFAULT_OPCODE_SIZE-1:0] OP_ALU_IMM = 7'b0010011;
    localparam logic [DEFAULT_OPCODE_SIZE-1:0] OP_BRANCH  = 7'b1100011;

endpackage
`default_nettype wire

// File: rtl/seq_register_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_register_file: 2^N x DATA_SIZE registers, one write, two bypassed    |
// | combinational reads. Revision: 1.0                                       |
// +--------------------------------------------------------------------------+
module seq_register_file
    import seq_stage_read_pkg::*;
#(
    parameter int DATA_SIZE     = DEFAULT_DATA_SIZE,
    parameter int REG_ADDR_SIZE = DEFAULT_REG_ADDR_SIZE
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            write_enable,
    input  logic        [REG_ADDR_SIZE-1:0] write_addr,
    input  logic signed [DATA_SIZE-1:0]     write_data,
    input  logic        [REG_ADDR_SIZE-1:0] read_addr1,
    input  logic        [REG_ADDR_SIZE-1:0] read_addr2,
    output logic signed [DATA_SIZE-1:0]     read_data1,
    output logic signed [DATA_SIZE-1:0]     read_data2
);

    localparam int REG_COUNT = 1 << REG_ADDR_SIZE;

    logic signed [DATA_SIZE-1:0] regs [REG_COUNT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable) begin
            regs[write_addr] <= write_data;
        end
    end

    // Bypass makes the value being written visible in the same cycle.
    always_comb begin
        read_data1 = (write_enable && write_addr == read_addr1) ? write_data : regs[read_addr1];
        read_data2 = (write_enable && write_addr == read_addr2) ? write_data : regs[read_addr2];
    end

endmodule
`default_nettype wire

// File: rtl/seq_stage_read.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_stage_read: operand fetch with load-use scoreboard and READ->EXECUTE |
// | pipeline register. Revision: 1.0                                         |
// +--------------------------------------------------------------------------+
module seq_stage_read
    import seq_stage_read_pkg::*;
#(
    parameter int DATA_SIZE     = DEFAULT_DATA_SIZE,
    parameter int REG_ADDR_SIZE = DEFAULT_REG_ADDR_SIZE,
    parameter int OPCODE_SIZE   = DEFAULT_OPCODE_SIZE
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_valid,
    input  logic        [OPCODE_SIZE-1:0]   i_opcode,
    input  logic        [REG_ADDR_SIZE-1:0] i_source1,
    input  logic        [REG_ADDR_SIZE-1:0] i_source2,
    input  logic                            i_use_source1,
    input  logic                            i_use_source2,
    input  logic        [REG_ADDR_SIZE-1:0] i_destination,
    input  logic                            i_data_source,
    input  logic        [REG_ADDR_SIZE-1:0] i_wb_destination,
    input  logic signed [DATA_SIZE-1:0]     i_wb_result,
    input  logic                            i_wb_register_file_write,
    input  logic                            i_stall,
    input  logic                            i_flush,
    output logic                            o_hazard,
    output logic                            o_valid,
    output logic        [OPCODE_SIZE-1:0]   o_opcode,
    output logic        [REG_ADDR_SIZE-1:0] o_destination,
    output logic                            o_data_source,
    output logic signed [DATA_SIZE-1:0]     o_operand1,
    output logic signed [DATA_SIZE-1:0]     o_operand2
);

    localparam int REG_COUNT = 1 << REG_ADDR_SIZE;

    logic signed [DATA_SIZE-1:0] rd1;
    logic signed [DATA_SIZE-1:0] rd2;
    logic [REG_COUNT-1:0]        pending;
    logic [REG_COUNT-1:0]        pending_next;
    logic                        hz1;
    logic                        hz2;
    logic                        capture;
    logic                        accept;

    seq_register_file #(
        .DATA_SIZE     (DATA_SIZE),
        .REG_ADDR_SIZE (REG_ADDR_SIZE)
    ) u_register_file (
        .clk          (i_clk),
        .rst_n        (i_rst_n),
        .write_enable (i_wb_register_file_write),
        .write_addr   (i_wb_destination),
        .write_data   (i_wb_result),
        .read_addr1   (i_source1),
        .read_addr2   (i_source2),
        .read_data1   (rd1),
        .read_data2   (rd2)
    );

    // A pending load whose result is being written this cycle is no longer a hazard.
    always_comb begin
        hz1      = i_use_source1 && pending[i_source1]
                   && !(i_wb_register_file_write && i_wb_destination == i_source1);
        hz2      = i_use_source2 && pending[i_source2]
                   && !(i_wb_register_file_write && i_wb_destination == i_source2);
        o_hazard = i_valid && (hz1 || hz2) && !i_flush;
        capture  = !i_flush && !i_stall;
        accept   = capture && i_valid && !o_hazard;
    end

    // Order matters: clears first so a same-cycle set on the same register wins.
    always_comb begin
        pending_next = pending;
        if (i_wb_register_file_write) begin
            pending_next[i_wb_destination] = 1'b0;
        end
        if (i_flush && o_valid && o_data_source) begin
            pending_next[o_destination] = 1'b0;
        end
        if (accept && i_data_source) begin
            pending_next[i_destination] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid       <= 1'b0;
            o_opcode      <= '0;
            o_destination <= '0;
            o_data_source <= 1'b0;
            o_operand1    <= '0;
            o_operand2    <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (!i_stall) begin
            o_valid       <= i_valid && !o_hazard;
            o_opcode      <= i_opcode;
            o_destination <= i_destination;
            o_data_source <= i_data_source;
            o_operand1    <= rd1;
            o_operand2    <= rd2;
        end
    end

endmodule
`default_nettype wire

// File: doc/seq_stage_read.md
Name: seq_stage_read

Overview:
- Read (operand-fetch) stage of the core pipeline; the consumer side of the register file that the write stage feeds.
- Contains the 8 x DATA_SIZE register file with one write port, driven by the write-stage outputs, and two combinational read ports with write-to-read bypass.
- Contains a load scoreboard that stalls decode on load-use hazards.
- Contains the READ→EXECUTE pipeline register with stall and flush.

Parameters:
- DATA_SIZE, 32, register/operand width
- REG_ADDR_SIZE, 3, register index width (2^3 = 8 registers)
- OPCODE_SIZE, 7, opcode field width passed through to execute

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_valid  in  1  decode presents a valid instruction
- i_opcode  in  OPCODE_SIZE  opcode from decode
- i_source1  in  REG_ADDR_SIZE  first source register
- i_source2  in  REG_ADDR_SIZE  second source register
- i_use_source1  in  1  instruction reads source1
- i_use_source2  in  1  instruction reads source2
- i_destination  in  REG_ADDR_SIZE  destination register
- i_data_source  in  1  1 = load (result comes from data memory)
- i_wb_destination  in  REG_ADDR_SIZE  write-stage destination
- i_wb_result  in  signed DATA_SIZE  write-stage result
- i_wb_register_file_write  in  1  write-stage write enable
- i_stall  in  1  execute cannot accept; hold output register
- i_flush  in  1  branch taken; kill the instruction in the output register and the one at the input
- o_hazard  out  1  decode must hold its instruction this cycle
- o_valid  out  1  output register valid
- o_opcode  out  OPCODE_SIZE  registered opcode
- o_destination  out  REG_ADDR_SIZE  registered destination
- o_data_source  out  1  registered load flag
- o_operand1  out  signed DATA_SIZE  registered source1 value
- o_operand2  out  signed DATA_SIZE  registered source2 value

Behaviour:
- Reset (i_rst_n = 0 at an edge):
  - all 8 registers ← 0; pending[7:0] ← 0.
  - o_valid, o_opcode, o_destination, o_data_source, o_operand1, o_operand2 ← 0.
  - o_hazard is combinational; it is 0 once pending is cleared.
- Register file:
  - write at the edge when i_wb_register_file_write = 1: reg[i_wb_destination] ← i_wb_result.
  - all 8 registers are writable; no hardwired zero.
- Read ports (combinational): rdN = (i_wb_register_file_write && i_wb_destination == i_sourceN) ? i_wb_result : reg[i_sourceN].
  - bypass gives same-cycle visibility of the value being written.
- Hazard:
  - hzN = i_use_sourceN && pending[i_sourceN] && !(i_wb_register_file_write && i_wb_destination == i_sourceN).
  - o_hazard = i_valid && (hz1 || hz2) && !i_flush.
- Output register update, priority reset > flush > stall > capture:
  - flush: o_valid ← 0, other outputs unchanged.
  - stall (no flush): all outputs hold. o_hazard is still computed combinationally; decode holds in either case.
  - capture: o_valid ← i_valid && !o_hazard. On a bubble (o_hazard = 1) the other fields may load but are don't-care. When valid, the fields ← i_opcode, i_destination, i_data_source, rd1, rd2.
  - Latency: 1 cycle from an accepted input to o_valid.
- Scoreboard pending[r], evaluated per edge:
  - set: capture of a valid load (i_data_source = 1) with destination r.
  - clear: wb write to r.
  - revoke: flush while o_valid && o_data_source; pending[o_destination] is cleared because that load never reaches write-back.
  - set wins over wb-clear on the same r in the same cycle.
  - revoke applies only to the register in the output register.
  - a stalled output register holding a load keeps its pending bit.
- Non-loads never set pending; results of ALU ops are forwarded by execute, outside this block.
- Reset mid-operation discards all in-flight state, including pending bits and register contents.

Decomposition:
- Shared package/defines:
  - REG_COUNT = 8 and register index width.
  - DATA_SIZE default.
  - opcode width and opcode constants, already in core_defines.vh.
- One sub-module: seq_register_file, holding the 8 x DATA_SIZE array, synchronous write, two combinational read ports with bypass, and synchronous reset.
- Scoreboard, hazard logic and output register stay in seq_stage_read.

Test Plan:
- Reset then read: hold i_rst_n = 0 for 2 cycles; issue source1 = 3, source2 = 5 → o_operand1 = o_operand2 = 0 and o_valid = 1 one cycle later.
- Bypass: wb writes reg2 = 0x0000_00AA in the same cycle that source1 = 2 is issued → o_operand1 = 0xAA next cycle; a later read of reg2 (no wb) → 0xAA.
- Load-use: load with dest 4 captured, then an add using source1 = 4 → o_hazard = 1, o_valid = 0 each cycle until wb writes reg4 = 0x1234. In that cycle o_hazard = 0, and the next cycle gives o_valid = 1, o_operand1 = 0x1234.
- Stall: i_stall = 1 for 3 cycles with new inputs changing → all outputs hold their captured values; release → the next input is captured.
- Flush of a load: load dest 6 in the output register, i_flush = 1 → o_valid = 0 and pending[6] = 0; a following read of source1 = 6 gives o_hazard = 0.
- Set/clear collision: wb writes reg1 while a new load with dest 1 is captured → pending[1] = 1; the next instruction using source1 = 1 sees o_hazard = 1.
